// File: rtl/vga_sync_module.sv
// VGA raster timing: free-running pixel/line counters with registered
// sync, visible-window and coordinate outputs, all aligned one clk late.
module vga_sync_module #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        hsync_sig,
  output logic        vsync_sig,
  output logic        ready_sig,
  output logic [10:0] col_addr_sig,
  output logic [10:0] row_addr_sig,
  output logic        line_start_sig,
  output logic        frame_start_sig
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SEND  = 11'(H_SYNC);
  localparam logic [10:0] V_SEND  = 11'(V_SYNC);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] H_STOP  = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] V_STOP  = 11'(V_SYNC + V_BACK + V_ACTIVE);

  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        h_wrap;
  logic        v_wrap;
  logic        h_vis;
  logic        v_vis;
  logic        active;

  always_comb begin
    h_wrap = (hcnt == H_LAST);
    v_wrap = (vcnt == V_LAST);
    h_vis  = (hcnt >= H_START) && (hcnt < H_STOP);
    v_vis  = (vcnt >= V_START) && (vcnt < V_STOP);
    active = h_vis && v_vis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_wrap ? '0 : vcnt + 11'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Coordinates only subtract inside the window, so they never underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_sig       <= 1'b1;
      vsync_sig       <= 1'b1;
      ready_sig       <= 1'b0;
      col_addr_sig    <= '0;
      row_addr_sig    <= '0;
      line_start_sig  <= 1'b0;
      frame_start_sig <= 1'b0;
    end else begin
      hsync_sig       <= (hcnt >= H_SEND);
      vsync_sig       <= (vcnt >= V_SEND);
      ready_sig       <= active;
      col_addr_sig    <= active ? hcnt - H_START : '0;
      row_addr_sig    <= active ? vcnt - V_START : '0;
      line_start_sig  <= (hcnt == '0);
      frame_start_sig <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench for vga_sync_module: default and reduced-size instances checked
// against a position-arithmetic model, constant vectors and event counts.
module tb_vga_sync_module;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic        ls;
    logic        fs;
    logic [10:0] col;
    logic [10:0] row;
  } obs_t;

  typedef struct {
    int unsigned edge_n;
    obs_t        want;
  } vec_t;

  localparam obs_t RST = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};

  localparam int SHS = 8;
  localparam int SHB = 6;
  localparam int SHA = 20;
  localparam int SHF = 4;
  localparam int SVS = 2;
  localparam int SVB = 3;
  localparam int SVA = 10;
  localparam int SVF = 2;
  localparam int SHT = SHS + SHB + SHA + SHF;
  localparam int SFR = SHT * (SVS + SVB + SVA + SVF);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_hs, d_vs, d_rdy, d_ls, d_fs;
  logic [10:0] d_col, d_row;
  logic        s_hs, s_vs, s_rdy, s_ls, s_fs;
  logic [10:0] s_col, s_row;
  obs_t        d_obs, s_obs;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  int unsigned t = 0;

  assign d_obs = {d_hs, d_vs, d_rdy, d_ls, d_fs, d_col, d_row};
  assign s_obs = {s_hs, s_vs, s_rdy, s_ls, s_fs, s_col, s_row};

  always #5 clk = ~clk;

  vga_sync_module dut_def (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsync_sig       (d_hs),
    .vsync_sig       (d_vs),
    .ready_sig       (d_rdy),
    .col_addr_sig    (d_col),
    .row_addr_sig    (d_row),
    .line_start_sig  (d_ls),
    .frame_start_sig (d_fs)
  );

  vga_sync_module #(
    .H_SYNC(SHS), .H_BACK(SHB), .H_ACTIVE(SHA), .H_FRONT(SHF),
    .V_SYNC(SVS), .V_BACK(SVB), .V_ACTIVE(SVA), .V_FRONT(SVF)
  ) dut_sml (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsync_sig       (s_hs),
    .vsync_sig       (s_vs),
    .ready_sig       (s_rdy),
    .col_addr_sig    (s_col),
    .row_addr_sig    (s_row),
    .line_start_sig  (s_ls),
    .frame_start_sig (s_fs)
  );

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else t <= t + 1;
  end

  function automatic obs_t mk(input logic hs, input logic vs,
                              input logic rdy, input logic ls,
                              input logic fs, input int col,
                              input int row);
    return {hs, vs, rdy, ls, fs, 11'(col), 11'(row)};
  endfunction

  // After k edges the outputs describe raster position k-1 of the frame.
  function automatic obs_t model(input int unsigned tt,
                                 input int hs, input int hb,
                                 input int ha, input int hf,
                                 input int vs, input int vb,
                                 input int va, input int vf);
    int  ht, vt, p, h, v;
    bit  act;
    if (tt == 0) return RST;
    ht  = hs + hb + ha + hf;
    vt  = vs + vb + va + vf;
    p   = int'((tt - 1) % (ht * vt));
    h   = p % ht;
    v   = p / ht;
    act = (h >= hs + hb) && (h < hs + hb + ha) &&
          (v >= vs + vb) && (v < vs + vb + va);
    return mk(h >= hs, v >= vs, act, h == 0, p == 0,
              act ? h - hs - hb : 0, act ? v - vs - vb : 0);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("hs=%0b vs=%0b rdy=%0b ls=%0b fs=%0b col=%0d row=%0d",
                     o.hs, o.vs, o.rdy, o.ls, o.fs, o.col, o.row);
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %s, need %s", name, t, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk_int(input string name, input int got, input int need);
    n_chk++;
    if (got != need) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return d_hs;
      1:       return s_hs;
      default: return s_vs;
    endcase
  endfunction

  // Falling-edge to falling-edge period and low width of one sync output.
  task automatic measure(input int sel, input int bound,
                         output int period, output int width);
    int   n, t1, t2, rise;
    logic prev, cur;
    n = 0; t1 = -1; t2 = -1; rise = -1;
    period = -1; width = -1;
    prev = pick(sel);
    while (n < bound && t2 < 0) begin
      step(1);
      n++;
      cur = pick(sel);
      if (prev && !cur) begin
        if (t1 < 0) t1 = n;
        else t2 = n;
      end
      if (!prev && cur && t1 >= 0 && rise < 0) rise = n;
      prev = cur;
    end
    if (t2 >= 0) period = t2 - t1;
    if (rise >= 0) width = rise - t1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("def_model", d_obs, model(t, 96, 48, 640, 16, 2, 33, 480, 10));
      chk("sml_model", s_obs, model(t, SHS, SHB, SHA, SHF,
                                    SVS, SVB, SVA, SVF));
    end
  end

  vec_t tbl[15];
  int   per, wid, n, g;
  int   rc, lc, fc, orphan, fcol, frow, lcol, lrow;

  initial begin
    tbl[0]  = '{1,     mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[1]  = '{2,     mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{3,     mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{96,    mk(0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{97,    mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{145,   mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{801,   mk(0, 0, 0, 1, 0, 0, 0)};
    tbl[7]  = '{1600,  mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1601,  mk(0, 1, 0, 1, 0, 0, 0)};
    tbl[9]  = '{28144, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[10] = '{28145, mk(1, 1, 1, 0, 0, 0, 0)};
    tbl[11] = '{28146, mk(1, 1, 1, 0, 0, 1, 0)};
    tbl[12] = '{28784, mk(1, 1, 1, 0, 0, 639, 0)};
    tbl[13] = '{28785, mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[14] = '{28945, mk(1, 1, 1, 0, 0, 0, 1)};

    repeat (3) @(posedge clk);
    #1;
    chk("cold_reset_def", d_obs, RST);
    chk("cold_reset_sml", s_obs, RST);
    chk_on = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Constant vectors on the default-size instance, by edge number.
    for (int i = 0; i < 15; i++) begin
      g = 0;
      while (t != tbl[i].edge_n && g < 40000) begin
        step(1);
        g++;
      end
      chk($sformatf("vec_edge_%0d", tbl[i].edge_n), d_obs, tbl[i].want);
    end

    measure(0, 2000, per, wid);
    chk_int("def_hsync_period", per, 800);
    chk_int("def_hsync_low", wid, 96);

    // Mid-frame reset on the small raster at row 5 / col 7.
    n = 0;
    while (!(s_rdy && s_row == 11'd5 && s_col == 11'd7) && n < 2000) begin
      step(1);
      n++;
    end
    chk_int("sml_found_r5c7", int'(s_rdy && s_row == 11'd5 && s_col == 11'd7), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("warm_reset_def", d_obs, RST);
    chk("warm_reset_sml", s_obs, RST);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
    chk_int("warm_fs_edge1", int'({d_fs, s_fs}), 3);
    n = 1;
    while (!s_rdy && n < 1000) begin
      step(1);
      n++;
    end
    chk_int("warm_first_rdy_edge", n, SHT * (SVS + SVB) + SHS + SHB + 1);

    // Three whole frames of the small raster, starting on a frame pulse.
    n = 0;
    while (!s_fs && n < 2000) begin
      step(1);
      n++;
    end
    chk_int("sml_fs_found", int'(s_fs), 1);
    for (int f = 0; f < 3; f++) begin
      rc = 0; lc = 0; fc = 0; orphan = 0;
      fcol = -1; frow = -1; lcol = -1; lrow = -1;
      for (int i = 0; i < SFR; i++) begin
        if (s_rdy) begin
          rc++;
          if (fcol < 0) begin
            fcol = int'(s_col);
            frow = int'(s_row);
          end
          lcol = int'(s_col);
          lrow = int'(s_row);
        end
        if (s_ls) lc++;
        if (s_fs) begin
          fc++;
          if (!s_ls) orphan++;
        end
        step(1);
      end
      chk_int($sformatf("f%0d_ready_count", f), rc, SHA * SVA);
      chk_int($sformatf("f%0d_line_starts", f), lc, SVS + SVB + SVA + SVF);
      chk_int($sformatf("f%0d_frame_starts", f), fc, 1);
      chk_int($sformatf("f%0d_fs_without_ls", f), orphan, 0);
      chk_int($sformatf("f%0d_first_col", f), fcol, 0);
      chk_int($sformatf("f%0d_first_row", f), frow, 0);
      chk_int($sformatf("f%0d_last_col", f), lcol, SHA - 1);
      chk_int($sformatf("f%0d_last_row", f), lrow, SVA - 1);
    end

    measure(1, 200, per, wid);
    chk_int("sml_hsync_period", per, SHT);
    chk_int("sml_hsync_low", wid, SHS);
    measure(2, 2000, per, wid);
    chk_int("sml_vsync_period", per, SFR);
    chk_int("sml_vsync_low", wid, SHT * SVS);

    // Random-length resets at random points; the model tracks restarts.
    for (int k = 0; k < 4; k++) begin
      step(int'($urandom_range(1, 900)));
      #(int'($urandom_range(1, 3)));
      rst_n = 1'b0;
      #1;
      chk($sformatf("rand_reset_def_%0d", k), d_obs, RST);
      chk($sformatf("rand_reset_sml_%0d", k), s_obs, RST);
      step(int'($urandom_range(1, 4)));
      rst_n = 1'b1;
    end
    step(SFR + 50);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
